// File: rtl/pic_loader_pkg.sv
// Shared definitions for the picture loader.
//   FRAME_W/FRAME_H : default frame geometry in pixels
//   TILE_W/TILE_H   : default tile geometry; six tiles cover one frame
//   CNT_W           : width of the row and column counters
//   state_t         : loader control states
//   pixel_t         : one {r,g,b} pixel, one bit per channel
package pic_loader_pkg;

  localparam int FRAME_W = 512;
  localparam int FRAME_H = 384;
  localparam int TILE_W  = 256;
  localparam int TILE_H  = 128;
  localparam int CNT_W   = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOAD
  } state_t;

  typedef logic [2:0] pixel_t;

endpackage

// File: rtl/pic_loader_raster_counter.sv
// Raster position counter for the loader.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : move the position to the origin (0,0)
//   step       : advance one pixel in raster order; wraps after the final pixel
//                clear together with step means the origin pixel is consumed
//                this cycle, so the position becomes (0,1)
//   row, col   : current position
//   last       : current position is the final pixel of the frame
module raster_counter
  import pic_loader_pkg::*;
#(
  parameter int FRAME_W = pic_loader_pkg::FRAME_W,
  parameter int FRAME_H = pic_loader_pkg::FRAME_H
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             last
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(FRAME_H - 1);

  logic col_end;

  assign col_end = (col == COL_LAST);
  assign last    = col_end && (row == ROW_LAST);

  // NOTE: async reset lives in the sensitivity list; state uses <= only so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear && step) begin
      row <= '0;
      col <= CNT_W'(1);
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (col_end) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_loader.sv
// Loads one raster frame from a pixel stream into six tile memories.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle request to load a frame (ignored while busy)
//   s_valid     : pixel beat valid
//   s_sof       : beat is pixel (0,0)
//   s_data      : pixel {r,g,b}
//   s_ready     : beat accepted this cycle when s_valid is high
//   we          : tile memory write enable (one cycle after acceptance)
//   wsel        : tile index {row/TILE_H, col/TILE_W}
//   waddr       : tile-local address {row%TILE_H, col%TILE_W}
//   wdata       : pixel written
//   busy        : waiting for start-of-frame or loading
//   frame_done  : pulses with the write of the final pixel
//   resync      : pulses with the write of a start-of-frame beat seen mid-frame
module pic_loader #(
  parameter int FRAME_W = pic_loader_pkg::FRAME_W,
  parameter int FRAME_H = pic_loader_pkg::FRAME_H,
  parameter int TILE_W  = pic_loader_pkg::TILE_W,
  parameter int TILE_H  = pic_loader_pkg::TILE_H
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_valid,
  input  logic        s_sof,
  input  logic [2:0]  s_data,
  output logic        s_ready,
  output logic        we,
  output logic [2:0]  wsel,
  output logic [14:0] waddr,
  output logic [2:0]  wdata,
  output logic        busy,
  output logic        frame_done,
  output logic        resync
);

  import pic_loader_pkg::*;

  localparam int COL_BITS = $clog2(TILE_W);
  localparam int ROW_BITS = $clog2(TILE_H);

  state_t           state;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] col;
  logic             last;
  logic             cnt_clear;
  logic             cnt_step;

  raster_counter #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .step  (cnt_step),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  // Ready and busy decode straight from the state flop, so they drop with reset.
  assign s_ready = (state != ST_IDLE);
  assign busy    = (state != ST_IDLE);

  // A start-of-frame beat is always written at the origin, so the counter is
  // told to consume (0,0) rather than the position it currently holds.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    cnt_clear = 1'b0;
    cnt_step  = 1'b0;
    case (state)
      ST_IDLE: cnt_clear = start;
      ST_SYNC: begin
        cnt_clear = s_valid && s_sof;
        cnt_step  = s_valid && s_sof;
      end
      ST_LOAD: begin
        cnt_clear = s_valid && s_sof;
        cnt_step  = s_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      we         <= 1'b0;
      wsel       <= '0;
      waddr      <= '0;
      wdata      <= '0;
      frame_done <= 1'b0;
      resync     <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      resync     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_SYNC;
        end
        ST_SYNC: begin
          // Beats before the first start-of-frame are accepted and dropped.
          if (s_valid && s_sof) begin
            we    <= 1'b1;
            wsel  <= '0;
            waddr <= '0;
            wdata <= s_data;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            we    <= 1'b1;
            wdata <= s_data;
            if (s_sof) begin
              wsel   <= '0;
              waddr  <= '0;
              resync <= 1'b1;
            end else begin
              wsel  <= {row[CNT_W-1:ROW_BITS], col[CNT_W-1:COL_BITS]};
              waddr <= {row[ROW_BITS-1:0], col[COL_BITS-1:0]};
              if (last) begin
                frame_done <= 1'b1;
                state      <= ST_IDLE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_loader.sv
// Self-checking bench for pic_loader. A reduced frame geometry still spans
// both tile columns and two tile rows. The reference model tracks the raster
// position as plain integers and derives tile/address by division.
module tb_pic_loader;

  localparam int FW   = 304;
  localparam int FH   = 131;
  localparam int NPIX = FW * FH;

  typedef struct packed {
    logic [2:0]  sel;
    logic [14:0] addr;
    logic [2:0]  data;
    logic        done;
    logic        rs;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic        s_sof;
  logic [2:0]  s_data;
  logic        s_ready;
  logic        we;
  logic [2:0]  wsel;
  logic [14:0] waddr;
  logic [2:0]  wdata;
  logic        busy;
  logic        frame_done;
  logic        resync;

  int n_assert = 0;
  int n_fail   = 0;

  wr_t exp_q[$];
  wr_t act_q[$];

  // Reference model state: 0 = waiting for start, 1 = waiting for sof, 2 = loading.
  int m_mode = 0;
  int m_row  = 0;
  int m_col  = 0;

  pic_loader #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .TILE_W  (256),
    .TILE_H  (128)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_sof      (s_sof),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .we         (we),
    .wsel       (wsel),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .frame_done (frame_done),
    .resync     (resync)
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed write (or pulse) must match the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (we || frame_done || resync)) begin
      wr_t obs;
      wr_t e;
      obs = '{sel: wsel, addr: waddr, data: wdata, done: frame_done, rs: resync};
      act_q.push_back(obs);
      n_assert++;
      if (!we) begin
        n_fail++;
        $display("FAIL pulse_without_write: we=%b done=%b resync=%b, required a write", we, frame_done, resync);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got sel=%0d addr=%h data=%0d, required no write", wsel, waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_fail++;
          $display("FAIL write_stream: got sel=%0d addr=%h data=%0d done=%b rs=%b, required sel=%0d addr=%h data=%0d done=%b rs=%b",
                   obs.sel, obs.addr, obs.data, obs.done, obs.rs, e.sel, e.addr, e.data, e.done, e.rs);
        end
      end
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push_exp(input int r, input int c, input logic [2:0] d,
                                   input logic done, input logic rs);
    wr_t e;
    e.sel  = 3'((r / 128) * 2 + ((c >= 256) ? 1 : 0));
    e.addr = 15'((r % 128) * 256 + (c % 256));
    e.data = d;
    e.done = done;
    e.rs   = rs;
    exp_q.push_back(e);
  endfunction

  // Spec-level behaviour of one clock edge given the inputs presented.
  function automatic void model_step(input logic st, input logic v, input logic sof,
                                     input logic [2:0] d);
    case (m_mode)
      0: if (st) m_mode = 1;
      1: if (v && sof) begin
        push_exp(0, 0, d, 1'b0, 1'b0);
        m_row = 0; m_col = 1; m_mode = 2;
      end
      default: if (v) begin
        if (sof) begin
          push_exp(0, 0, d, 1'b0, 1'b1);
          m_row = 0; m_col = 1;
        end else begin
          logic is_last;
          is_last = (m_row == FH - 1) && (m_col == FW - 1);
          push_exp(m_row, m_col, d, is_last, 1'b0);
          if (is_last) begin
            m_mode = 0; m_row = 0; m_col = 0;
          end else begin
            m_col++;
            if (m_col == FW) begin
              m_col = 0;
              m_row++;
            end
          end
        end
      end
    endcase
  endfunction

  // Presents inputs for one cycle; entered and left just after a rising edge.
  task automatic cycle(input logic st, input logic v, input logic sof, input logic [2:0] d);
    start = st; s_valid = v; s_sof = sof; s_data = d;
    #1;
    n_assert++;
    if (s_ready !== (m_mode != 0)) begin
      n_fail++;
      $display("FAIL s_ready: got %b, required %b (t=%0t)", s_ready, (m_mode != 0), $time);
    end
    @(posedge clk);
    model_step(st, v, sof, d);
    #1;
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 3'd0);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: %0d expected writes never observed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    start = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    m_mode = 0; m_row = 0; m_col = 0;
    exp_q.delete();
    act_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    n_assert++;
    if ({s_ready, we, busy, frame_done, resync, wsel, waddr, wdata} !== '0) begin
      n_fail++;
      $display("FAIL %s: got s_ready=%b we=%b busy=%b done=%b rs=%b wsel=%0d waddr=%h wdata=%0d, required all 0",
               tag, s_ready, we, busy, frame_done, resync, wsel, waddr, wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = 3'd0;
    #3;
    check_outputs_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("after_reset_release");
  endtask

  task automatic test_full_frame();
    int ndone;
    hard_reset();
    cycle(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < NPIX; i++) begin
      logic [2:0] d;
      d = (i == 130 * FW + 300) ? 3'b101 : 3'($urandom);
      cycle(1'b0, 1'b1, (i == 0), d);
    end
    drain();
    n_assert++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end_idle: got busy=%b s_ready=%b, required 0 0", busy, s_ready);
    end
    ndone = 0;
    foreach (act_q[i]) if (act_q[i].done) ndone++;
    n_assert++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL frame_done_count: got %0d, required 1", ndone);
    end
    n_assert++;
    if (act_q.size() != NPIX) begin
      n_fail++;
      $display("FAIL frame_write_count: got %0d, required %0d", act_q.size(), NPIX);
    end else begin
      n_assert++;
      if (act_q[NPIX-1].done !== 1'b1 || act_q[NPIX-1].sel !== 3'd3 || act_q[NPIX-1].addr !== 15'h022F) begin
        n_fail++;
        $display("FAIL last_pixel: got done=%b sel=%0d addr=%h, required 1 3 022f",
                 act_q[NPIX-1].done, act_q[NPIX-1].sel, act_q[NPIX-1].addr);
      end
      n_assert++;
      if (act_q[130*FW+300].sel !== 3'd3 || act_q[130*FW+300].addr !== 15'h022C ||
          act_q[130*FW+300].data !== 3'b101) begin
        n_fail++;
        $display("FAIL pixel_130_300: got sel=%0d addr=%h data=%0d, required 3 022c 5",
                 act_q[130*FW+300].sel, act_q[130*FW+300].addr, act_q[130*FW+300].data);
      end
    end
  endtask

  task automatic test_sync_discard();
    hard_reset();
    cycle(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 3'($urandom));
    cycle(1'b0, 1'b1, 1'b1, 3'd6);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 3'($urandom));
    drain();
    n_assert++;
    if (act_q.size() != 5) begin
      n_fail++;
      $display("FAIL sync_write_count: got %0d, required 5", act_q.size());
    end else begin
      n_assert++;
      if (act_q[0].sel !== 3'd0 || act_q[0].addr !== 15'd0 || act_q[0].data !== 3'd6) begin
        n_fail++;
        $display("FAIL sync_first_write: got sel=%0d addr=%h data=%0d, required 0 0000 6",
                 act_q[0].sel, act_q[0].addr, act_q[0].data);
      end
    end
  endtask

  task automatic test_resync();
    localparam int RS_IDX = 10 * FW + 20;
    hard_reset();
    cycle(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < RS_IDX + 4; i++)
      cycle(1'b0, 1'b1, (i == 0) || (i == RS_IDX), 3'($urandom));
    drain();
    n_assert++;
    if (act_q.size() != RS_IDX + 4) begin
      n_fail++;
      $display("FAIL resync_write_count: got %0d, required %0d", act_q.size(), RS_IDX + 4);
    end else begin
      n_assert++;
      if (act_q[RS_IDX].rs !== 1'b1 || act_q[RS_IDX].addr !== 15'd0 || act_q[RS_IDX].sel !== 3'd0) begin
        n_fail++;
        $display("FAIL resync_beat: got rs=%b sel=%0d addr=%h, required 1 0 0000",
                 act_q[RS_IDX].rs, act_q[RS_IDX].sel, act_q[RS_IDX].addr);
      end
      n_assert++;
      if (act_q[RS_IDX+1].rs !== 1'b0 || act_q[RS_IDX+1].addr !== 15'd1) begin
        n_fail++;
        $display("FAIL resync_next: got rs=%b addr=%h, required 0 0001",
                 act_q[RS_IDX+1].rs, act_q[RS_IDX+1].addr);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int nwr;
    hard_reset();
    cycle(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 1000; i++) cycle(1'b0, 1'b1, (i == 0), 3'($urandom));
    s_valid = 1'b1;
    s_sof   = 1'b0;
    @(negedge clk);
    #1;
    n_assert++;
    if (we !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_write: got we=%b, required 1", we);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset_mid_frame");
    m_mode = 0; m_row = 0; m_col = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nwr = act_q.size();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, (i % 2 == 0), 3'($urandom));
    drain();
    n_assert++;
    if (act_q.size() != nwr) begin
      n_fail++;
      $display("FAIL write_after_reset: got %0d writes, required 0", act_q.size() - nwr);
    end
    cycle(1'b1, 1'b0, 1'b0, 3'd0);
    cycle(1'b0, 1'b1, 1'b1, 3'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 3'($urandom));
    drain();
    n_assert++;
    if (act_q.size() != nwr + 4) begin
      n_fail++;
      $display("FAIL restart_write_count: got %0d, required 4", act_q.size() - nwr);
    end
  endtask

  task automatic test_gaps_and_start();
    int sent;
    int ngap;
    hard_reset();
    cycle(1'b1, 1'b0, 1'b0, 3'd0);
    sent = 0;
    ngap = 0;
    while (sent < 3000) begin
      logic v;
      logic st;
      v  = 1'($urandom);
      st = ($urandom_range(0, 19) == 0);
      cycle(st, v, v && (sent == 0), 3'($urandom));
      if (v) sent++;
      else ngap++;
    end
    drain();
    n_assert++;
    if (act_q.size() != 3000) begin
      n_fail++;
      $display("FAIL gap_write_count: got %0d, required 3000 (gaps=%0d)", act_q.size(), ngap);
    end
    n_assert++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_mid_frame: got %b, required 1", busy);
    end
  endtask

  initial begin
    test_reset();
    test_sync_discard();
    test_resync();
    test_reset_mid_frame();
    test_gaps_and_start();
    test_full_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_loader.md
PIC_LOADER -- requirements
Module: pic_loader

Interface
REQ-001 Parameter FRAME_W, default 512, frame width in pixels.
REQ-002 Parameter FRAME_H, default 384, frame height in pixels.
REQ-003 Parameter TILE_W, default 256, tile width; TILE_H, default 128, tile height.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle request to load one frame.
REQ-007 s_valid  input  1  pixel beat valid.
REQ-008 s_sof  input  1  beat is pixel (0,0); qualified by s_valid.
REQ-009 s_data  input  3  pixel {r,g,b}, 1 bit per channel.
REQ-010 s_ready  output  1  loader accepts beat this cycle.
REQ-011 we  output  1  tile memory write enable.
REQ-012 wsel  output  3  tile index 0..5, {row/128, col>=256}.
REQ-013 waddr  output  15  tile-local address {row[6:0], col[7:0]}.
REQ-014 wdata  output  3  pixel written.
REQ-015 busy  output  1  high in SYNC or LOAD.
REQ-016 frame_done  output  1  one-cycle pulse on final write of a frame.
REQ-017 resync  output  1  one-cycle pulse when s_sof arrives mid-frame.

Function
REQ-018 The block SHALL write a raster stream into six 256x128 tiles so that the display-side mapping (tile = {r/128, c>=256}, address = {r[6:0], c[7:0]}) reads back the same pixel at (r,c).
REQ-019 States: IDLE, SYNC, LOAD; one-hot or binary encoding is free.
REQ-020 IDLE: s_ready=0; start -> SYNC; other inputs ignored.
REQ-021 SYNC: s_ready=1; beats with s_sof=0 are accepted and discarded (no write); accepted beat with s_sof=1 is written as pixel (0,0), then -> LOAD with col=1,row=0.
REQ-022 LOAD: s_ready=1; each accepted beat (s_valid & s_ready) is written at current (row,col), then col increments; col wraps FRAME_W-1 -> 0 with row+1.
REQ-023 Accepted beat at (FRAME_H-1, FRAME_W-1) SHALL produce frame_done and the state SHALL become IDLE.
REQ-024 Accepted beat with s_sof=1 in LOAD SHALL be written as pixel (0,0), set col=1,row=0, and pulse resync.
REQ-025 start while busy SHALL be ignored.
REQ-026 Latency: we/wsel/waddr/wdata/frame_done/resync are registered, asserted exactly one cycle after the accepting edge; we=0 on cycles without an accepted, written beat.
REQ-027 s_valid=0 gaps SHALL stall counters with no write.
REQ-028 Counters: col 9 bits, row 9 bits; wsel[2:1]=row[8:7], wsel[0]=col[8]; no value outside 0..383/0..511 SHALL ever be driven.

Reset
REQ-029 rst_n low SHALL force IDLE, row=col=0, and s_ready, we, busy, frame_done, resync, wsel, waddr, wdata all 0, asynchronously.
REQ-030 Reset mid-LOAD SHALL abandon the frame with no further writes; a new start is required.

Structure
REQ-031 A shared package SHALL hold FRAME_W, FRAME_H, TILE_W, TILE_H, the state enum, and the pixel typedef (3-bit rgb).
REQ-032 One sub-module raster_counter SHALL hold row/col counters with clear, step, and last-pixel flag.

Verification
REQ-033 start, 196608 contiguous beats with s_sof on first -> 196608 writes, frame_done once, on the write of (383,511): wsel=5, waddr=0x7FFF.
REQ-034 Beat at (r=130, c=300), data 3'b101 -> wsel=3, waddr={7'd2, 8'd44}=0x022C, wdata=3'b101.
REQ-035 start, then 5 beats with s_sof=0, then sof beat -> no writes for first 5; first write wsel=0, waddr=0.
REQ-036 s_sof reasserted at pixel (10,20) -> resync pulse, that beat written at waddr=0, next at waddr=1.
REQ-037 rst_n low at pixel 1000 -> outputs 0 immediately; no writes until new start and sof.
REQ-038 Random s_valid gaps (50%) -> write sequence identical to gapless run; start during LOAD has no effect.
